key_scan_ctrl: RTL and testbench

Shared-counter scanner and event controller for up to N push-buttons. One FSM time-multiplexes a single debounce update datapath across all keys on a prescaled tick, and keeps a per-key saturating hysteresis counter in a register array. Debounced level or toggle state is presented per key, and press/release events are queued in a small FIFO for the CPU-side IO bus. It replaces per-key free-running debouncers in the IO subsystem.

---
 rtl/key_scan_ctrl_pkg.sv | 28 ++
 rtl/key_scan_ctrl_if.sv | 20 ++
 rtl/key_scan_ctrl_fifo.sv | 64 ++++++
 rtl/key_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_key_scan_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/key_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keyscan_pkg
// Purpose  : Shared types for the key scanner: FSM states, event record and
//            the key-index width helper.
// Revision : 1.0  initial release
// ============================================================================
package keyscan_pkg;

  typedef enum logic [0:0] {
    WAIT = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Widest key index for the supported 2..16 key range
  localparam int KEY_W_MAX = 4;

  typedef struct packed {
    logic [KEY_W_MAX-1:0] key;
    logic                 press;
  } event_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : key_scan_ctrl_if
// Purpose  : Valid/ready event bus between the key scanner and its consumer.
// Revision : 1.0  initial release
// ============================================================================
interface key_scan_ctrl_if #(
  parameter int KEY_W = 3
) ();

  logic             ev_valid;
  logic             ev_ready;
  logic [KEY_W-1:0] ev_key;
  logic             ev_press;

  modport master (output ev_valid, output ev_key, output ev_press, input ev_ready);
  modport slave  (input ev_valid, input ev_key, input ev_press, output ev_ready);

endinterface
`default_nettype wire

// File: rtl/key_scan_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keyscan_fifo
// Purpose  : Synchronous event FIFO, valid/ready read side, same-cycle
//            push/pop, reports pushes that had to be dropped.
// Revision : 1.0  initial release
// ============================================================================
module keyscan_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              drop_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_w, push_ok_w;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign pop_w     = ready_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs
  assign push_ok_w = push_i & (~full_o | pop_w);
  assign drop_o    = push_i & full_o & ~pop_w;
  assign valid_o   = ~empty_o;
  assign data_o    = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok_w && !pop_w) count_d = count_q + 1'b1;
    if (pop_w && !push_ok_w) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_w)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_w) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/key_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_scan_ctrl
// Purpose  : Time-multiplexed debouncer for N push-buttons with event FIFO.
//            Optional auto-repeat enabled by defining KEYSCAN_REPEAT_EN.
// Revision : 1.0  initial release
// ============================================================================
module key_scan_ctrl
  import keyscan_pkg::*;
#(
  parameter int N_KEYS     = 8,
  parameter int TICK_DIV   = 50000,
  parameter int DEB_TICKS  = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_DELAY  = 40,
  parameter int REP_RATE   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys_in,
  input  logic [N_KEYS-1:0] mode,
  output logic [N_KEYS-1:0] key_state,
  output logic              ovf,
  input  logic              ovf_clr,
  key_scan_ctrl_if.master   ev
);

  localparam int IDX_W   = idx_width(N_KEYS);
  localparam int CNT_W   = $clog2(DEB_TICKS + 1);
  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam bit PARAMS_OK = (TICK_DIV > N_KEYS + 2) && (REP_DELAY > 0) && (REP_RATE > 0);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PRESC_W-1:0] presc_q;
  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [N_KEYS-1:0] stable_q, key_state_q;
  logic              ovf_q, ovf_d;

  logic              tick_w, slot_w;
  logic [CNT_W-1:0]  cur_cnt_w, cnt_d;
  logic              cur_stable_w, cur_ks_w, in_w;
  logic              rise_w, fall_w, rep_fire_w;
  logic              stable_d, ks_d;
  logic              push_w, drop_w;
  event_t            push_ev_w, head_w;

  assign tick_w = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign slot_w = (state_q == SCAN);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      WAIT: if (tick_w) begin
        state_d = SCAN;
        idx_d   = '0;
      end
      SCAN: if (idx_q == IDX_W'(N_KEYS - 1)) state_d = WAIT;
            else idx_d = idx_q + 1'b1;
      default: state_d = WAIT;
    endcase
  end

  // Single shared hysteresis update for the key in the current slot
  always_comb begin
    cur_cnt_w    = cnt_q[idx_q];
    cur_stable_w = stable_q[idx_q];
    cur_ks_w     = key_state_q[idx_q];
    in_w         = sync2_q[idx_q];
    cnt_d        = cur_cnt_w;
    if (in_w) begin
      if (cur_cnt_w != CNT_W'(DEB_TICKS)) cnt_d = cur_cnt_w + 1'b1;
    end else begin
      if (cur_cnt_w != '0) cnt_d = cur_cnt_w - 1'b1;
    end
    rise_w   = slot_w & (cnt_d == CNT_W'(DEB_TICKS)) & ~cur_stable_w;
    fall_w   = slot_w & (cnt_d == '0) & cur_stable_w;
    stable_d = rise_w ? 1'b1 : (fall_w ? 1'b0 : cur_stable_w);
    ks_d     = mode[idx_q] ? (cur_ks_w ^ (rise_w | rep_fire_w)) : stable_d;
  end

`ifdef KEYSCAN_REPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic             rep_act_q, rep_first_q;
  logic [IDX_W-1:0] rep_key_q;
  logic [REP_W-1:0] rep_cnt_q, rep_limit_w;
  logic             rep_mine_w;

  assign rep_limit_w = rep_first_q ? REP_W'(REP_DELAY) : REP_W'(REP_RATE);
  assign rep_mine_w  = slot_w & rep_act_q & (rep_key_q == idx_q);
  assign rep_fire_w  = rep_mine_w & cur_stable_w & ~fall_w & (rep_cnt_q + 1'b1 == rep_limit_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
      rep_key_q   <= '0;
      rep_cnt_q   <= '0;
    end else if (rise_w) begin
      rep_act_q   <= 1'b1;
      rep_first_q <= 1'b1;
      rep_key_q   <= idx_q;
      rep_cnt_q   <= '0;
    end else if (rep_mine_w) begin
      if (fall_w) begin
        rep_act_q <= 1'b0;
      end else if (rep_fire_w) begin
        rep_first_q <= 1'b0;
        rep_cnt_q   <= '0;
      end else begin
        rep_cnt_q <= rep_cnt_q + 1'b1;
      end
    end
  end
`else
  assign rep_fire_w = 1'b0;
`endif

  assign push_w          = rise_w | fall_w | rep_fire_w;
  assign push_ev_w.key   = KEY_W_MAX'(idx_q);
  assign push_ev_w.press = ~fall_w;
  assign ovf_d           = drop_w ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT;
      idx_q       <= '0;
      presc_q     <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      key_state_q <= '0;
      ovf_q       <= 1'b0;
      for (int k = 0; k < N_KEYS; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= tick_w ? '0 : presc_q + 1'b1;
      sync1_q <= keys_in;
      sync2_q <= sync1_q;
      ovf_q   <= ovf_d;
      if (slot_w) begin
        cnt_q[idx_q]       <= cnt_d;
        stable_q[idx_q]    <= stable_d;
        key_state_q[idx_q] <= ks_d;
      end
    end
  end

  keyscan_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W ($bits(event_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_w),
    .data_i  (push_ev_w),
    .valid_o (ev.ev_valid),
    .ready_i (ev.ev_ready),
    .data_o  (head_w),
    .full_o  (),
    .empty_o (),
    .drop_o  (drop_w)
  );

  assign ev.ev_key   = IDX_W'(head_w.key);
  assign ev.ev_press = head_w.press;
  assign key_state   = key_state_q;
  assign ovf         = ovf_q;

  // A new tick must never land while a sweep is still running
  a_no_tick_in_scan: assert property (@(posedge clk) disable iff (rst)
    PARAMS_OK && !(tick_w && state_q == SCAN));

endmodule
`default_nettype wire

// File: tb/tb_key_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_scan_ctrl
// Purpose  : Scoreboard bench for key_scan_ctrl with a tick-level key model.
// Revision : 1.0  initial release
// ============================================================================
module tb_key_scan_ctrl;

  localparam int NK = 4;
  localparam int DT = 3;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] keys_in = '0;
  logic [NK-1:0] mode = '0;
  logic [NK-1:0] key_state;
  logic          ovf;
  logic          ovf_clr = 1'b0;

  key_scan_ctrl_if #(.KEY_W(2)) bus ();

  key_scan_ctrl #(
    .N_KEYS(NK), .TICK_DIV(8), .DEB_TICKS(DT), .FIFO_DEPTH(FD),
    .REP_DELAY(40), .REP_RATE(8)
  ) dut (
    .clk(clk), .rst(rst), .keys_in(keys_in), .mode(mode),
    .key_state(key_state), .ovf(ovf), .ovf_clr(ovf_clr), .ev(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int key;
    bit press;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Tick-level reference state
  int   m_cnt[NK];
  bit   m_stable[NK];
  bit   m_ks[NK];
  bit   m_ovf;
  bit   m_ready;
  int   m_pend;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NK; k++) begin
      m_cnt[k] = 0; m_stable[k] = 0; m_ks[k] = 0;
    end
    m_ovf = 0; m_ready = 1; m_pend = 0;
  endfunction

  function automatic void emit(input int k, input bit p);
    exp_t e;
    e.key = k; e.press = p;
    if (m_ready) exp_q.push_back(e);
    else if (m_pend < FD) begin
      exp_q.push_back(e);
      m_pend++;
    end else m_ovf = 1;
  endfunction

  function automatic int model_ks();
    int v = 0;
    for (int k = 0; k < NK; k++) if (m_ks[k]) v += (1 << k);
    return v;
  endfunction

  // One scan tick: every key in ascending order sees the level held this period
  function automatic void model_step(input logic [NK-1:0] kv, input logic [NK-1:0] md);
    for (int k = 0; k < NK; k++) begin
      if (kv[k]) m_cnt[k] = (m_cnt[k] < DT) ? m_cnt[k] + 1 : DT;
      else       m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
      if (m_cnt[k] == DT && !m_stable[k]) begin
        m_stable[k] = 1;
        m_ks[k] = md[k] ? !m_ks[k] : 1'b1;
        emit(k, 1'b1);
      end else if (m_cnt[k] == 0 && m_stable[k]) begin
        m_stable[k] = 0;
        if (!md[k]) m_ks[k] = 0;
        emit(k, 1'b0);
      end else if (!md[k]) begin
        m_ks[k] = m_stable[k];
      end
    end
  endfunction

  // One tick period; entered 4 cycles after a tick so no sweep is in flight
  task automatic period(input logic [NK-1:0] kv, input logic [NK-1:0] md,
                        input bit rdy, input bit clr, input string tag);
    check({tag, " key_state"}, int'(key_state), model_ks());
    check({tag, " ovf"}, int'(ovf), int'(m_ovf));
    keys_in = kv; mode = md; bus.ev_ready = rdy; ovf_clr = clr;
    if (clr) m_ovf = 0;
    if (rdy && !m_ready) m_pend = 0;
    m_ready = rdy;
    model_step(kv, md);
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    repeat (7) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.ev_valid && bus.ev_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_event: got key %0d press %0d, expected none",
                 bus.ev_key, bus.ev_press);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_key", int'(bus.ev_key), e.key);
        check("event_press", int'(bus.ev_press), int'(e.press));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NK-1:0] rk, rm;
    logic [NK-1:0] bounce [9];
    bounce = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    bus.ev_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset ev_valid", int'(bus.ev_valid), 0);
    check("reset ev_key", int'(bus.ev_key), 0);
    check("reset ev_press", int'(bus.ev_press), 0);
    check("reset ovf", int'(ovf), 0);
    check("reset key_state", int'(key_state), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    repeat (3) period(4'b0100, 4'b0000, 1, 0, "press2");
    repeat (3) period(4'b0000, 4'b0000, 1, 0, "rel2");
    for (int i = 0; i < 9; i++) period(bounce[i], 4'b0000, 1, 0, "bounce1");
    repeat (2) begin
      repeat (3) period(4'b0001, 4'b0001, 1, 0, "tog0_on");
      repeat (3) period(4'b0000, 4'b0001, 1, 0, "tog0_off");
    end

    repeat (3) period(4'b1001, 4'b0000, 0, 0, "fill_p03");
    repeat (3) period(4'b0000, 4'b0000, 0, 0, "fill_r03");
    repeat (3) period(4'b0100, 4'b0000, 0, 0, "fill_drop");
    period(4'b0100, 4'b0000, 0, 1, "ovf_clr");
    period(4'b0100, 4'b0000, 1, 0, "drain");
    repeat (3) period(4'b0000, 4'b0000, 1, 0, "rel2b");
    repeat (3) period(4'b1001, 4'b0000, 1, 0, "same_tick");
    repeat (3) period(4'b0000, 4'b0000, 1, 0, "same_rel");

    repeat (3) period(4'b0100, 4'b0000, 1, 0, "pre_rst");
    repeat (2) period(4'b0101, 4'b0000, 1, 0, "pre_rst0");
    check("rst_setup key_state", int'(key_state), model_ks());
    keys_in = 4'b0101; bus.ev_ready = 1'b0; m_ready = 0;
    model_step(4'b0101, 4'b0000);
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst ev_valid", int'(bus.ev_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst ev_valid", int'(bus.ev_valid), 0);
    check("mid_rst ev_key", int'(bus.ev_key), 0);
    check("mid_rst ev_press", int'(bus.ev_press), 0);
    check("mid_rst key_state", int'(key_state), 0);
    check("mid_rst ovf", int'(ovf), 0);
    exp_q.delete();
    model_reset();
    keys_in = '0; bus.ev_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    rk = '0; rm = '0;
    for (int i = 0; i < 80; i++) begin
      rk = rk ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 7) == 0) rm = 4'($urandom);
      period(rk, rm, 1, 0, "random");
    end
    period(rk, rm, 1, 0, "final");
    repeat (8) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
